// File: rtl/loader_pkg.sv
// Shared state encoding and widths for the program loader.
// PROGRAM_LOADER_CHECKSUM_EN adds the trailing checksum byte to the byte-accepting states.
package loader_pkg;

    localparam int INSTR_W = 16;
    localparam int BYTE_W  = 8;

    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } loaderState_e;

    function automatic logic takesByte(input loaderState_e s);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA_LO) ||
               (s == DATA_HI) || (s == CSUM);
`else
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA_LO) ||
               (s == DATA_HI);
`endif
    endfunction

endpackage

// File: rtl/loader_timer.sv
// Idle watchdog for the byte stream: reloads on clear, counts down while run,
// and flags expiry on the TIMEOUT-th consecutive idle cycle. TIMEOUT of 0 disables it.
module loader_timer #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] remain_q, remain_d;

    always_comb begin
        remain_d = remain_q;
        if (clear) begin
            remain_d = LOAD_VAL;
        end else if (run && (remain_q != '0)) begin
            remain_d = remain_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remain_q <= '0;
        end else begin
            remain_q <= remain_d;
        end
    end

    // Expiry fires during the last idle cycle so the FSM reaches ERROR on that edge.
    assign expired = (TIMEOUT != 0) && run && (remain_q == CNT_W'(1));

endmodule

// File: rtl/program_loader.sv
// Downloads a length-prefixed little-endian program into the icache while holding the CPU.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_req,
    input  logic                 in_valid,
    input  logic [BYTE_W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 cpu_hold,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [INSTR_W-1:0]   wr_data,
    output logic                 load_done,
    output logic                 load_error,
    output logic [ADDR_W:0]      words_loaded
);

    localparam logic [31:0] CAPACITY = 32'(1) << ADDR_W;

    loaderState_e        state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [ADDR_W:0]     wordCount_q, wordCount_d;
    logic [BYTE_W-1:0]   byteLo_q, byteLo_d;
    logic [BYTE_W-1:0]   byteHi_q, byteHi_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum_q, csum_d;
`endif

    logic        accepting;
    logic        xfer;
    logic        timerExpired;
    logic [15:0] lenFull;

    assign accepting = takesByte(state_q);
    assign xfer      = in_valid && accepting;
    assign lenFull   = {in_data, len_q[7:0]};

    loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!accepting || xfer),
        .run     (accepting && !xfer),
        .expired (timerExpired)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wordCount_d = wordCount_q;
        byteLo_d    = byteLo_q;
        byteHi_d    = byteHi_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE, ERROR: begin
                if (load_req) begin
                    state_d     = LEN_LO;
                    wordCount_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d      = '0;
`endif
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    if (lenFull == 16'd0) begin
                        state_d = DONE;
                    end else if (32'(lenFull) > CAPACITY) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA_LO;
                    end
                end
            end
            DATA_LO: begin
                if (xfer) begin
                    byteLo_d = in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d   = csum_q ^ in_data;
`endif
                    state_d  = DATA_HI;
                end
            end
            DATA_HI: begin
                if (xfer) begin
                    byteHi_d = in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d   = csum_q ^ in_data;
`endif
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                wordCount_d = wordCount_q + 1'b1;
                if ((32'(wordCount_q) + 32'd1) == 32'(len_q)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA_LO;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? DONE : ERROR;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A stalled source aborts the download regardless of which byte was pending.
        if (timerExpired) begin
            state_d = ERROR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            wordCount_q <= '0;
            byteLo_q    <= '0;
            byteHi_q    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wordCount_q <= wordCount_d;
            byteLo_q    <= byteLo_d;
            byteHi_q    <= byteHi_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign in_ready     = accepting;
    assign cpu_hold     = (state_q != IDLE) && (state_q != DONE);
    assign wr_en        = (state_q == WRITE);
    assign wr_addr      = wr_en ? wordCount_q[ADDR_W-1:0] : '0;
    assign wr_data      = wr_en ? {byteHi_q, byteLo_q} : '0;
    assign load_done    = (state_q == DONE);
    assign load_error   = (state_q == ERROR);
    assign words_loaded = wordCount_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader checked against a queue-based download model.
// Honours PROGRAM_LOADER_CHECKSUM_EN by appending and checking the trailing checksum byte.
module tb_program_loader;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                load_req = 1'b0;
    logic                in_valid = 1'b0;
    logic [7:0]          in_data = 8'h00;
    logic                in_ready;
    logic                cpu_hold;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [15:0]         wr_data;
    logic                load_done;
    logic                load_error;
    logic [ADDR_W:0]     words_loaded;

    int vecCount  = 0;
    int failCount = 0;
    int doneSeen  = 0;

    logic [7:0]          progQ[$];
    logic [ADDR_W+15:0]  obsQ[$];
    logic [ADDR_W+15:0]  expQ[$];
    int                  expWords;
    bit                  expErr;

    always #5 clk = ~clk;

    program_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_req     (load_req),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .cpu_hold     (cpu_hold),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
        end
    endtask

    // Icache write and done-pulse observer.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_en) begin
                obsQ.push_back({wr_addr, wr_data});
                checkOutput("ready_low_in_write", 32'(in_ready), 32'd0);
            end
            if (load_done) doneSeen++;
        end
    end

    function automatic int progLen();
        return int'(progQ[0]) + 256 * int'(progQ[1]);
    endfunction

    // Reference: what the icache and flags should look like after this byte stream.
    task automatic modelProgram();
        int len;
        logic [7:0] x;
        expQ.delete();
        expErr   = 1'b0;
        expWords = 0;
        len = progLen();
        if (len > (2 ** ADDR_W)) begin
            expErr = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < len; i++) begin
            expQ.push_back({ADDR_W'(i), progQ[3 + 2 * i], progQ[2 + 2 * i]});
            x = x ^ progQ[2 + 2 * i] ^ progQ[3 + 2 * i];
        end
        expWords = len;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (len != 0 && progQ[2 + 2 * len] != x) expErr = 1'b1;
`endif
    endtask

    task automatic appendCsum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = 2; i < progQ.size(); i++) x ^= progQ[i];
        progQ.push_back(x);
`endif
    endtask

    task automatic makeProgram(input int nWords);
        progQ.delete();
        progQ.push_back(8'(nWords));
        progQ.push_back(8'(nWords >> 8));
        for (int i = 0; i < 2 * nWords; i++) progQ.push_back(8'($urandom));
        appendCsum();
    endtask

    task automatic startLoad();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        checkOutput("hold_after_req", 32'(cpu_hold), 32'd1);
        checkOutput("error_cleared", 32'(load_error), 32'd0);
        checkOutput("words_cleared", 32'(words_loaded), 32'd0);
    endtask

    // Presents one byte (after an optional idle gap) and returns at the negedge after acceptance.
    task automatic sendByte(input logic [7:0] b, input int gap, input bit noise, output bit ok);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        ok       = 1'b0;
        for (int t = 0; t < 40; t++) begin
            load_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            checkOutput("hold_busy", 32'(cpu_hold), 32'd1);
            if (in_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        load_req = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int gapMax, input bit noise);
        bit ok;
        int len;
        obsQ.delete();
        doneSeen = 0;
        modelProgram();
        len = progLen();
        startLoad();
        for (int i = 0; i < progQ.size(); i++) begin
            sendByte(progQ[i], (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0, noise, ok);
            checkOutput("byte_accepted", 32'(ok), 32'd1);
            if (!ok) break;
            if (len > 0 && len <= (2 ** ADDR_W) && i >= 3 && i < 2 + 2 * len && (i % 2) == 1)
                checkOutput("write_latency", 32'(wr_en), 32'd1);
        end
        for (int t = 0; t < 20; t++) begin
            if (load_done || load_error || doneSeen > 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        checkOutput("load_error", 32'(load_error), 32'(expErr));
        checkOutput("done_pulses", 32'(doneSeen), expErr ? 32'd0 : 32'd1);
        checkOutput("hold_final", 32'(cpu_hold), 32'(expErr));
        checkOutput("words_loaded", 32'(words_loaded), 32'(expWords));
        checkOutput("write_count", 32'(obsQ.size()), 32'(expQ.size()));
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++)
            checkOutput($sformatf("write_%0d", i), 32'(obsQ[i]), 32'(expQ[i]));
    endtask

    initial begin
        bit ok;
        int n;

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_load_done", 32'(load_done), 32'd0);
        checkOutput("rst_load_error", 32'(load_error), 32'd0);
        checkOutput("rst_words", 32'(words_loaded), 32'd0);
        reset_n = 1'b1;

        $display("[TB] two-word directed program");
        progQ.delete();
        progQ.push_back(8'h02); progQ.push_back(8'h00);
        progQ.push_back(8'h34); progQ.push_back(8'h12);
        progQ.push_back(8'h78); progQ.push_back(8'h56);
        appendCsum();
        applyStimulus(0, 1'b0);

        $display("[TB] empty program");
        makeProgram(0);
        applyStimulus(0, 1'b0);

        $display("[TB] oversize header 257");
        progQ.delete();
        progQ.push_back(8'h01); progQ.push_back(8'h01);
        applyStimulus(0, 1'b0);

        $display("[TB] four words with random gaps");
        makeProgram(4);
        applyStimulus(5, 1'b0);

        $display("[TB] random programs");
        for (int k = 0; k < 6; k++) begin
            makeProgram(int'($urandom_range(1, 8)));
            applyStimulus(5, 1'b1);
        end

        $display("[TB] full capacity 256 words");
        makeProgram(256);
        applyStimulus(0, 1'b0);

        $display("[TB] source stall timeout");
        obsQ.delete();
        startLoad();
        sendByte(8'h02, 0, 1'b0, ok);
        sendByte(8'h00, 0, 1'b0, ok);
        sendByte(8'h34, 0, 1'b0, ok);
        n = 0;
        for (int t = 0; t < 100; t++) begin
            if (load_error) break;
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycles", 32'(n), 32'(TIMEOUT));
        checkOutput("timeout_hold", 32'(cpu_hold), 32'd1);
        checkOutput("timeout_no_write", 32'(obsQ.size()), 32'd0);

        $display("[TB] reset during DATA_HI");
        startLoad();
        sendByte(8'h01, 0, 1'b0, ok);
        sendByte(8'h00, 0, 1'b0, ok);
        sendByte(8'hAA, 0, 1'b0, ok);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("mid_rst_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("mid_rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("mid_rst_error", 32'(load_error), 32'd0);
        checkOutput("mid_rst_words", 32'(words_loaded), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_idle", 32'(cpu_hold), 32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        $display("[TB] checksum good and bad");
        progQ.delete();
        progQ.push_back(8'h01); progQ.push_back(8'h00);
        progQ.push_back(8'h34); progQ.push_back(8'h12); progQ.push_back(8'h26);
        applyStimulus(0, 1'b0);
        progQ[4] = 8'h27;
        applyStimulus(0, 1'b0);
`endif

        $display("[TB] recovery program");
        makeProgram(3);
        applyStimulus(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
